// File: rtl/rs_cmd_debouncer.sv
// Debounces two raw buttons and turns accepted rising edges into spaced, non-overlapping
// set/reset pulses for a downstream RS trigger; reset requests win over set requests.
module rs_cmd_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PULSE_WIDTH     = 1,
  parameter int unsigned HOLDOFF_CYCLES  = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_set,
  input  logic btn_reset,
  output logic s,
  output logic r,
  output logic busy,
  output logic overrun
);

  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TmrMax = (PULSE_WIDTH > HOLDOFF_CYCLES) ? PULSE_WIDTH : HOLDOFF_CYCLES;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);

  localparam logic [DbW-1:0]  DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TmrW-1:0] PwLoad = TmrW'(PULSE_WIDTH - 1);
  localparam logic [TmrW-1:0] HoLoad = TmrW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

  // Channel index: bit 0 = set, bit 1 = reset.
  localparam int unsigned ChS = 0;
  localparam int unsigned ChR = 1;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_db
    $error("DEBOUNCE_CYCLES out of range 1..255");
  end
  if (PULSE_WIDTH < 1 || PULSE_WIDTH > 15) begin : g_bad_pw
    $error("PULSE_WIDTH out of range 1..15");
  end
  if (HOLDOFF_CYCLES > 15) begin : g_bad_ho
    $error("HOLDOFF_CYCLES out of range 0..15");
  end

  typedef enum logic [1:0] {
    StIdle,
    StPulseS,
    StPulseR,
    StHoldoff
  } state_e;

  logic [1:0]           sync1_q, sync1_d;
  logic [1:0]           sync2_q, sync2_d;
  logic [1:0]           db_q, db_d;
  logic [1:0]           db_prev_q, db_prev_d;
  logic [1:0][DbW-1:0]  cnt_q, cnt_d;
  logic [1:0]           pend_q, pend_d;
  logic [TmrW-1:0]      tmr_q, tmr_d;
  state_e               state_q, state_d;
  logic                 s_q, s_d;
  logic                 r_q, r_d;
  logic                 busy_q, busy_d;
  logic                 ovr_q, ovr_d;

  logic [1:0]           rise;
  logic [1:0]           clr;
  logic                 dispatch;

  // Synchronizer and per-channel debounce counters.
  always_comb begin
    sync1_d   = {btn_reset, btn_set};
    sync2_d   = sync1_q;
    db_d      = db_q;
    cnt_d     = cnt_q;
    db_prev_d = db_q;
    for (int c = 0; c < 2; c++) begin
      if (sync2_q[c] != db_q[c]) begin
        if (cnt_q[c] == DbLast) begin
          db_d[c]  = ~db_q[c];
          cnt_d[c] = '0;
        end else begin
          cnt_d[c] = cnt_q[c] + DbW'(1);
        end
      end else begin
        cnt_d[c] = '0;
      end
    end
  end

  // Command FSM: leaving IDLE or finishing HOLDOFF both go through the same dispatch.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    clr      = 2'b00;
    dispatch = 1'b0;
    unique case (state_q)
      StIdle: dispatch = 1'b1;
      StPulseS, StPulseR: begin
        if (tmr_q == '0) begin
          if (HOLDOFF_CYCLES == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StHoldoff;
            tmr_d   = HoLoad;
          end
        end else begin
          tmr_d = tmr_q - TmrW'(1);
        end
      end
      StHoldoff: begin
        if (tmr_q == '0) begin
          dispatch = 1'b1;
        end else begin
          tmr_d = tmr_q - TmrW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (dispatch) begin
      if (pend_q[ChR]) begin
        state_d  = StPulseR;
        tmr_d    = PwLoad;
        clr[ChR] = 1'b1;
      end else if (pend_q[ChS]) begin
        state_d  = StPulseS;
        tmr_d    = PwLoad;
        clr[ChS] = 1'b1;
      end else begin
        state_d  = StIdle;
      end
    end
  end

  // A rise landing on an unserviced pending flag merges into it and is flagged as lost.
  always_comb begin
    rise   = db_q & ~db_prev_q;
    pend_d = (pend_q & ~clr) | rise;
    ovr_d  = |(rise & pend_q & ~clr);
    s_d    = (state_d == StPulseS);
    r_d    = (state_d == StPulseR);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      cnt_q     <= '0;
      pend_q    <= '0;
      tmr_q     <= '0;
      state_q   <= StIdle;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      tmr_q     <= tmr_d;
      state_q   <= state_d;
      s_q       <= s_d;
      r_q       <= r_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
    end
  end

  assign s       = s_q;
  assign r       = r_q;
  assign busy    = busy_q;
  assign overrun = ovr_q;

endmodule

// File: doc/rs_cmd_debouncer.md
RS_CMD_DEBOUNCER -- requirements
Module: rs_cmd_debouncer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive synchronized cycles an input must hold a new level before it is accepted (legal range 1..255).
REQ-002 The block SHALL have parameter PULSE_WIDTH, default 1, meaning the clock cycles each s/r command pulse lasts (legal range 1..15).
REQ-003 The block SHALL have parameter HOLDOFF_CYCLES, default 2, meaning the minimum idle cycles between consecutive command pulses (legal range 0..15).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 The block SHALL have port btn_set, input, 1, raw asynchronous bouncy set request.
REQ-007 The block SHALL have port btn_reset, input, 1, raw asynchronous bouncy reset request.
REQ-008 The block SHALL have port s, output, 1, registered set pulse driving the downstream RS trigger s input.
REQ-009 The block SHALL have port r, output, 1, registered reset pulse driving the downstream RS trigger r input.
REQ-010 The block SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-011 The block SHALL have port overrun, output, 1, one-cycle flag on a request lost by merging.

Function
REQ-012 The block SHALL pass each btn input through a 2-flop synchronizer; no other logic may sample raw btn inputs.
REQ-013 The block SHALL keep, per channel, an accepted level db_x and a counter that increments each cycle sync_x != db_x, clears when sync_x == db_x, and toggles db_x (counter cleared) when reaching DEBOUNCE_CYCLES.
REQ-014 The block SHALL set a per-channel pending flag one cycle after a 0->1 transition of db_x; falling transitions SHALL generate no request.
REQ-015 The block SHALL set overrun for one cycle when a rising db_x occurs while that channel's pending flag is already set; the requests merge into one.
REQ-016 The block SHALL implement FSM states IDLE, PULSE_S, PULSE_R, HOLDOFF.
REQ-017 In IDLE the FSM SHALL go to PULSE_R if reset-pending is set, else to PULSE_S if set-pending is set, else stay; the serviced pending flag clears on that transition.
REQ-018 Simultaneous set and reset pending SHALL be serviced reset first, then set after holdoff.
REQ-019 s SHALL be 1 exactly for the PULSE_WIDTH cycles the FSM is in PULSE_S; r likewise in PULSE_R; s and r SHALL never be 1 together.
REQ-020 After a pulse the FSM SHALL spend HOLDOFF_CYCLES cycles in HOLDOFF (skip directly to IDLE when 0), then return to IDLE.
REQ-021 Requests arising during PULSE_x or HOLDOFF SHALL remain pending and be serviced from IDLE per REQ-017.
REQ-022 With btn_set held stable high from sample edge 1, s SHALL rise at clock edge DEBOUNCE_CYCLES+4 (edge 8 for default).
REQ-023 An input level lasting fewer than DEBOUNCE_CYCLES synchronized cycles SHALL produce no pulse and no change of db_x.
REQ-024 Counters SHALL be sized $clog2(max+1) and SHALL never wrap.

Reset
REQ-025 While rst_n is 0 at a clock edge, s, r, busy, overrun, synchronizer flops, db_x, counters and pending flags SHALL become 0 and the FSM SHALL enter IDLE.
REQ-026 Reset asserted mid-pulse SHALL drop s/r at that edge; no aborted request SHALL be replayed after reset release.
REQ-027 After rst_n returns to 1, an input already high SHALL be debounced from zero and produce one pulse per REQ-022.

Verification
REQ-028 Defaults, btn_set 0->1 held -> s=1 on edge 8 only, busy high edges 8-10, r stays 0.
REQ-029 btn_reset glitches high 3 cycles, low 2, high 2 -> no r pulse, overrun 0.
REQ-030 btn_set and btn_reset rise same cycle -> r pulse at edge 8, s pulse at edge 11 (1 pulse + 2 holdoff), never overlapping.
REQ-031 PULSE_WIDTH=3, HOLDOFF_CYCLES=0, set then second clean set edge during pulse -> two s pulses of 3 cycles each, overrun only if third edge arrives before service.
REQ-032 rst_n low for 1 cycle during PULSE_S -> s 0 at that edge, all pending 0, no pulse until new debounced edge.
